// File: rtl/inst_loader_pkg.sv
// Shared types and constants for the instruction-memory byte loader.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package inst_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_CHECK = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int INST_DEPTH_DEFAULT = 14;
  localparam int WORD_BYTES         = 4;
  localparam int ADDR_W             = 32;

endpackage

// File: rtl/byte_packer.sv
// Packs a byte stream big-endian into 32-bit words (first byte -> [31:24]).
// Latency: word_next/word_ready are combinational with the 4th accepted byte.
// Backpressure: none; one byte accepted per enabled cycle, never stalls.
module byte_packer (
  input  logic        clock_in,
  input  logic        reset,
  input  logic        clear,
  input  logic        enable,
  input  logic [7:0]  byte_data,
  output logic [31:0] word_next,
  output logic        word_ready
);

  // Only the first three bytes need storage; the fourth is taken straight
  // from the input so the word is ready on the cycle it arrives.
  logic [23:0] shreg;
  logic [1:0]  byte_idx;

  // Shift accepted bytes in and count position within the word (wraps 3->0).
  always_ff @(posedge clock_in) begin
    if (reset || clear) begin
      shreg    <= 24'd0;
      byte_idx <= 2'd0;
    end else if (enable) begin
      shreg    <= {shreg[15:0], byte_data};
      byte_idx <= byte_idx + 2'd1;
    end
  end

  assign word_next  = {shreg, byte_data};
  assign word_ready = enable && (byte_idx == 2'd3);

endmodule

// File: rtl/inst_loader.sv
// Fills DEPTH instruction words from a byte stream, then flags done; optional trailing XOR check (INST_LOADER_CHECKSUM_EN).
// Latency: mem_we is high the cycle after the edge sampling each word's 4th byte.
// Backpressure: none; accepts one byte per cycle, ignores bytes outside LOAD/CHECK.
module inst_loader
  import inst_loader_pkg::*;
#(
  parameter int DEPTH = INST_DEPTH_DEFAULT,
  parameter int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clock_in,
  input  logic             reset,
  input  logic             start,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_wdata,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] word_count,
  output logic             chk_err
);

  localparam logic [1:0] S_IDLE  = 2'(ST_IDLE);
  localparam logic [1:0] S_LOAD  = 2'(ST_LOAD);
  localparam logic [1:0] S_CHECK = 2'(ST_CHECK);
  localparam logic [1:0] S_DONE  = 2'(ST_DONE);

  logic [1:0]       state;
  logic [1:0]       state_nxt;
  logic [CNT_W-1:0] word_cnt;   // doubles as the slot index of the next write
  logic             load_en;
  logic             clear_en;
  logic             word_ready;
  logic             last_word;
  logic [31:0]      word_next;

  assign load_en   = (state == S_LOAD) && byte_valid;
  assign clear_en  = ((state == S_IDLE) || (state == S_DONE)) && start;
  assign last_word = word_ready && (word_cnt == CNT_W'(DEPTH - 1));

  byte_packer u_packer (
    .clock_in   (clock_in),
    .reset      (reset),
    .clear      (clear_en),
    .enable     (load_en),
    .byte_data  (byte_data),
    .word_next  (word_next),
    .word_ready (word_ready)
  );

  // Next-state decode; unreachable encodings fall back to IDLE.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE, S_DONE: if (start) state_nxt = S_LOAD;
`ifdef INST_LOADER_CHECKSUM_EN
      S_LOAD:  if (last_word) state_nxt = S_CHECK;
      S_CHECK: if (byte_valid) state_nxt = S_DONE;
`else
      S_LOAD:  if (last_word) state_nxt = S_DONE;
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  // State, registered status flags, word counter and the write port.
  always_ff @(posedge clock_in) begin
    if (reset) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'd0;
      mem_wdata <= 32'd0;
      word_cnt  <= '0;
    end else begin
      state  <= state_nxt;
      busy   <= (state_nxt == S_LOAD) || (state_nxt == S_CHECK);
      done   <= (state_nxt == S_DONE);
      mem_we <= word_ready;
      if (clear_en) begin
        word_cnt <= '0;
      end else if (word_ready) begin
        word_cnt <= word_cnt + 1'b1;
      end
      if (word_ready) begin
        mem_addr  <= ADDR_W'(word_cnt) << $clog2(WORD_BYTES);
        mem_wdata <= word_next;
      end
    end
  end

  assign word_count = word_cnt;

`ifdef INST_LOADER_CHECKSUM_EN
  logic [7:0] xor_acc;

  // Running XOR of data bytes; the byte received in CHECK is compared to it.
  always_ff @(posedge clock_in) begin
    if (reset || clear_en) begin
      xor_acc <= 8'd0;
      chk_err <= 1'b0;
    end else if (load_en) begin
      xor_acc <= xor_acc ^ byte_data;
    end else if ((state == S_CHECK) && byte_valid) begin
      chk_err <= (byte_data != xor_acc);
    end
  end
`else
  assign chk_err = 1'b0;
`endif

endmodule

// File: doc/inst_loader.md
# inst_loader

Board-side loader that fills the instruction memory from a byte stream, e.g. the board UART receiver. It assembles incoming bytes big-endian into 32-bit words and writes them into consecutive word slots through a write port (`mem_we` / `mem_addr` / `mem_wdata`). It then flags completion so the CPU can be released from reset. It is the writer matching the instruction memory's read path: the memory is addressed by byte address, with the word index equal to `addr>>2`.

## Interface
Parameters:
- `DEPTH`, default 14: number of 32-bit words loaded per session (memory slots 0..DEPTH-1).
- `CNT_W`, default `$clog2(DEPTH+1)`: width of `word_count`.

Ports:
- `clock_in`  input  1: single clock; all state changes on the rising edge.
- `reset`  input  1: synchronous, active-high; returns the block to IDLE.
- `start`  input  1: one-cycle pulse that begins a load session.
- `byte_valid`  input  1: `byte_data` is valid this cycle; one byte per asserted cycle.
- `byte_data`  input  8: stream byte.
- `mem_we`  output  1: one-cycle write strobe to the instruction memory.
- `mem_addr`  output  32: byte address of the write, word-aligned (`word_idx<<2`).
- `mem_wdata`  output  32: assembled instruction word.
- `busy`  output  1: high in LOAD and CHECK.
- `done`  output  1: high in DONE.
- `word_count`  output  CNT_W: number of words written this session.
- `chk_err`  output  1: checksum mismatch; see Configuration.

## Operation
- States: IDLE, LOAD, CHECK (present only with the macro), DONE.
- **IDLE**:
  - `start` goes to LOAD.
  - On that transition, `byte_idx`, `word_idx`, `word_count`, the running XOR and `chk_err` clear.
  - `byte_valid` is ignored.
- **LOAD**:
  - Each `byte_valid` shifts `byte_data` into the assembly register. The first byte of a word lands in [31:24] and the fourth in [7:0].
  - `byte_idx` counts 0..3 and wraps.
  - When a byte is accepted with `byte_idx`==3:
    - `mem_wdata` is the full word.
    - `mem_addr` is `word_idx<<2`.
    - `mem_we` is 1 for exactly the next cycle.
    - `word_idx` and `word_count` increment.
  - When the accepted byte completes word DEPTH-1, the state goes to CHECK if the macro is defined, otherwise to DONE.
  - `start` during LOAD is ignored.
- **CHECK**: the next `byte_valid` byte is compared against the running XOR of all 4·DEPTH data bytes. On a mismatch, `chk_err` is set to 1. The state then goes to DONE.
- **DONE**:
  - Holds `done`=1, `word_count`=DEPTH and `chk_err`.
  - Further `byte_valid` bytes are ignored and never write.
  - `start` restarts exactly as from IDLE.
- Outputs are registered.
- `mem_addr` and `mem_wdata` hold their last value when `mem_we`=0. Their values while `mem_we`=0 carry no meaning.
- No writes go beyond slot DEPTH-1 under any input sequence.

## Timing
- Reset values:
  - state IDLE
  - `mem_we`=0, `mem_addr`=0, `mem_wdata`=0
  - `busy`=0, `done`=0, `word_count`=0, `chk_err`=0.
- Reset wins over every other input in the same cycle, including mid-word.
  - A partially assembled word is discarded and never written.
  - A `mem_we` that would have fired the cycle after the reset edge does not fire.
- `start` and `byte_valid` asserted in the same IDLE cycle: the state enters LOAD and that byte is dropped. The first accepted byte is on a later cycle.
- Back-to-back bytes are accepted at one per cycle with no bubbles.
- Write latency: `mem_we` is high in the cycle after the edge that samples the fourth byte.
- `busy` falls and `done` rises on the same edge that raises `mem_we` for the last word, in the build without the macro. With the macro, they change on the edge that samples the checksum byte.
- Idle gaps of any length between bytes are allowed. There is no timeout.

## Configuration
- Macro: `INST_LOADER_CHECKSUM_EN`.
- **Defined**:
  - The CHECK state exists.
  - One trailing checksum byte is expected; it equals the XOR of all data bytes.
  - `chk_err` reports the result of the comparison.
  - Words are still written during LOAD regardless of the check outcome.
- **Undefined**:
  - No CHECK state and no XOR register.
  - `chk_err` is tied to 0.
  - LOAD goes directly to DONE.

## Structure
- Package `inst_loader_pkg`:
  - state enum (IDLE/LOAD/CHECK/DONE)
  - `INST_DEPTH_DEFAULT` = 14
  - `WORD_BYTES` = 4
  - `ADDR_W` = 32.
- Sub-module `byte_packer`:
  - Contains the shift register, the 2-bit `byte_idx`, and a `word_ready` pulse.
  - Has clear and enable inputs.
  - It is the only natural split; the FSM, address counter and checksum stay in `inst_loader`.

## Test plan
- **Basic write.** Reset, `start`, then bytes 08 00 00 04 back-to-back. Required: exactly one `mem_we` cycle, one cycle after the fourth byte, with `mem_addr`=0x0 and `mem_wdata`=0x08000004.
- **Full load, no macro.** Stream 14 words, with slot 1 = 0x00221820 and slot 13 = 0xAC070001. Required: 14 strobes at addresses 0x00, 0x04 … 0x34, `done`=1 and `word_count`=14. Another 8 bytes sent afterwards produce no `mem_we`.
- **Reset mid-load.** Reset after 6 bytes, i.e. word 0 written and two bytes of word 1 received. Required: `busy`=0 and no strobe for word 1. A new `start` plus 4 bytes then writes `mem_addr`=0x0.
- **Gapped input and collisions.** Bytes separated by 0–5 idle cycles, with random `start` pulses during LOAD. Required: the same write sequence as back-to-back input, with no restart.
- **Checksum (macro defined).** 14 words followed by the correct XOR byte gives `done`=1, `chk_err`=0. Flipping bit 0 of the checksum byte gives `done`=1, `chk_err`=1.
- **Restart from DONE.** A `start` in DONE clears `done`, `word_count` and `chk_err` and gives `busy`=1. The next word writes `mem_addr`=0x0.
